// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock sequencer.
// Cycle constants assume the 27 MHz reference clock.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } pll_state_e;

  localparam int unsigned CLKIN_HZ           = 32'd27_000_000;
  localparam int unsigned DEF_PLL_RST_CYCLES = 32'd27;         // 1 us
  localparam int unsigned DEF_LOCK_TIMEOUT   = 32'd2_700_000;  // 100 ms
  localparam int unsigned DEF_STABLE_CYCLES  = 32'd2_700;      // 100 us
  localparam int unsigned DEF_HOLD_CYCLES    = 32'd270;        // 10 us
  localparam int unsigned DEF_CTR_W          = 32'd24;
  localparam int unsigned DEF_CNT_W          = 32'd8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow or level-type asynchronous inputs.
// Each bit is synchronised independently; no bus coherency is implied.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two back-to-back capture stages to let metastability resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Supervises a PLL from the reference-clock side: pulses the PLL reset,
// waits for a qualified lock, then releases a downstream reset/ready.
// Runs on clkin so it keeps working while the PLL output is unusable.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned CTR_W          = DEF_CTR_W,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             lock,
  input  logic             force_relock,
  output logic             pll_rst,
  output logic             rst_out,
  output logic             ready,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] lost_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] RST_LAST    = CTR_W'(PLL_RST_CYCLES - 32'd1);
  localparam logic [CTR_W-1:0] TIMEOUT_LAST = CTR_W'(LOCK_TIMEOUT - 32'd1);
  localparam logic [CTR_W-1:0] STABLE_LAST = CTR_W'(STABLE_CYCLES - 32'd1);
  localparam logic [CTR_W-1:0] HOLD_LAST   = CTR_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  pll_state_e       state_r;
  pll_state_e       nxt_state_s;
  logic [CTR_W-1:0] ctr_r;
  logic             ctr_clr_s;
  logic             retry_inc_s;
  logic             lost_inc_s;
  logic             lock_s;
  logic             pll_rst_r;
  logic             rst_out_r;
  logic             ready_r;
  logic [CNT_W-1:0] lost_cnt_r;
  logic [CNT_W-1:0] retry_cnt_r;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (lock),
    .q   (lock_s)
  );

  // Next-state decode; force_relock overrides every other transition.
  always_comb begin
    nxt_state_s = state_r;
    retry_inc_s = 1'b0;
    lost_inc_s  = 1'b0;
    case (state_r)
      ST_PLL_RST: begin
        if (force_relock) begin
          nxt_state_s = ST_PLL_RST;
        end else if (ctr_r == RST_LAST) begin
          nxt_state_s = ST_WAIT_LOCK;
        end else begin
          nxt_state_s = ST_PLL_RST;
        end
      end
      ST_WAIT_LOCK: begin
        if (force_relock) begin
          nxt_state_s = ST_PLL_RST;
        end else if (lock_s) begin
          nxt_state_s = ST_STABLE;
        end else if (ctr_r == TIMEOUT_LAST) begin
          nxt_state_s = ST_PLL_RST;
          retry_inc_s = 1'b1;
        end else begin
          nxt_state_s = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (force_relock) begin
          nxt_state_s = ST_PLL_RST;
        end else if (!lock_s) begin
          nxt_state_s = ST_WAIT_LOCK;
        end else if (ctr_r == STABLE_LAST) begin
          nxt_state_s = ST_HOLD;
        end else begin
          nxt_state_s = ST_STABLE;
        end
      end
      ST_HOLD: begin
        // A loss here is pre-qualification, so it is not counted as lost.
        if (force_relock) begin
          nxt_state_s = ST_PLL_RST;
        end else if (!lock_s) begin
          nxt_state_s = ST_WAIT_LOCK;
        end else if (ctr_r == HOLD_LAST) begin
          nxt_state_s = ST_RUN;
        end else begin
          nxt_state_s = ST_HOLD;
        end
      end
      ST_RUN: begin
        // A loss is counted even when a relock request wins the transition.
        lost_inc_s = ~lock_s;
        if (force_relock) begin
          nxt_state_s = ST_PLL_RST;
        end else if (!lock_s) begin
          nxt_state_s = ST_WAIT_LOCK;
        end else begin
          nxt_state_s = ST_RUN;
        end
      end
      default: begin
        nxt_state_s = ST_PLL_RST;
      end
    endcase
    // force_relock also restarts the count when already in PLL_RST.
    ctr_clr_s = (nxt_state_s != state_r) || force_relock;
  end

  // State, phase counter and outputs; outputs follow the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_r   <= ST_PLL_RST;
      ctr_r     <= '0;
      pll_rst_r <= 1'b1;
      rst_out_r <= 1'b1;
      ready_r   <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      if (ctr_clr_s) begin
        ctr_r <= '0;
      end else if (ctr_r != CTR_MAX) begin
        ctr_r <= ctr_r + {{(CTR_W-1){1'b0}}, 1'b1};
      end else begin
        ctr_r <= ctr_r;
      end
      pll_rst_r <= (nxt_state_s == ST_PLL_RST);
      rst_out_r <= (nxt_state_s != ST_RUN);
      ready_r   <= (nxt_state_s == ST_RUN);
    end
  end

  // Saturating diagnostic counters, cleared only by block reset.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lost_cnt_r  <= '0;
      retry_cnt_r <= '0;
    end else begin
      if (lost_inc_s && (lost_cnt_r != CNT_MAX)) begin
        lost_cnt_r <= lost_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (retry_inc_s && (retry_cnt_r != CNT_MAX)) begin
        retry_cnt_r <= retry_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign pll_rst   = pll_rst_r;
  assign rst_out   = rst_out_r;
  assign ready     = ready_r;
  assign state_o   = state_r;
  assign lost_cnt  = lost_cnt_r;
  assign retry_cnt = retry_cnt_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer using short
// simulation timing (reset 4, timeout 50, stable 8, hold 5 cycles).
module tb_pll_lock_sequencer;

  localparam int CNT_W = 8;

  logic             clkin;
  logic             reset;
  logic             lock;
  logic             force_relock;
  logic             pll_rst;
  logic             rst_out;
  logic             ready;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] lost_cnt;
  logic [CNT_W-1:0] retry_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (50),
    .STABLE_CYCLES  (8),
    .HOLD_CYCLES    (5),
    .CTR_W          (24),
    .CNT_W          (CNT_W)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .lock         (lock),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .rst_out      (rst_out),
    .ready        (ready),
    .state_o      (state_o),
    .lost_cnt     (lost_cnt),
    .retry_cnt    (retry_cnt)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask

  initial begin
    reset        = 1'b1;
    lock         = 1'b0;
    force_relock = 1'b0;
    step(3);
    chk("rst_state",   state_o,   32'd0);
    chk("rst_pll_rst", pll_rst,   32'd1);
    chk("rst_rst_out", rst_out,   32'd1);
    chk("rst_ready",   ready,     32'd0);
    chk("rst_lost",    lost_cnt,  32'd0);
    chk("rst_retry",   retry_cnt, 32'd0);

    // 1: reset pulse width and a lock timeout
    reset = 1'b0;
    step(3);
    chk("t1_pll_rst_hi", pll_rst, 32'd1);
    chk("t1_state_rst",  state_o, 32'd0);
    step(1);
    chk("t1_pll_rst_lo", pll_rst, 32'd0);
    chk("t1_state_wait", state_o, 32'd1);
    step(49);
    chk("t1_still_wait", state_o, 32'd1);
    chk("t1_retry0",     retry_cnt, 32'd0);
    step(1);
    chk("t1_timeout_st", state_o, 32'd0);
    chk("t1_retry1",     retry_cnt, 32'd1);
    chk("t1_repulse",    pll_rst, 32'd1);
    step(3);
    chk("t1_repulse_hi", pll_rst, 32'd1);
    step(1);
    chk("t1_repulse_lo", pll_rst, 32'd0);
    chk("t1_wait_again", state_o, 32'd1);

    // 2: lock rises 10 cycles into WAIT_LOCK, ready after 16 cycles
    step(10);
    lock = 1'b1;
    step(15);
    chk("t2_ready_early", ready,   32'd0);
    chk("t2_hold_state",  state_o, 32'd3);
    chk("t2_rst_out_hi",  rst_out, 32'd1);
    step(1);
    chk("t2_ready",       ready,   32'd1);
    chk("t2_rst_out_lo",  rst_out, 32'd0);
    chk("t2_state_run",   state_o, 32'd4);
    chk("t2_pll_rst",     pll_rst, 32'd0);

    // 3: lock loss in RUN, 3-cycle reaction, then requalify
    step(5);
    chk("t3_run_steady", ready, 32'd1);
    lock = 1'b0;
    step(2);
    chk("t3_ready_2cyc", ready,   32'd1);
    chk("t3_rst_2cyc",   rst_out, 32'd0);
    step(1);
    chk("t3_rst_out",    rst_out, 32'd1);
    chk("t3_ready_lo",   ready,   32'd0);
    chk("t3_lost1",      lost_cnt, 32'd1);
    chk("t3_state_wait", state_o, 32'd1);
    lock = 1'b1;
    step(15);
    chk("t3_req_early",  ready, 32'd0);
    step(1);
    chk("t3_req_ready",  ready, 32'd1);

    // 4: relock from RUN, then a 3-cycle lock glitch during STABLE
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    chk("t4_force_st",   state_o, 32'd0);
    chk("t4_force_lost", lost_cnt, 32'd1);
    chk("t4_force_rdy",  ready, 32'd0);
    step(3);
    chk("t4_rst_hold",   state_o, 32'd0);
    step(1);
    chk("t4_wait",       state_o, 32'd1);
    step(1);
    chk("t4_stable",     state_o, 32'd2);
    lock = 1'b0;
    step(2);
    chk("t4_glitch_st",  state_o, 32'd2);
    step(1);
    chk("t4_back_wait",  state_o, 32'd1);
    chk("t4_lost_same",  lost_cnt, 32'd1);
    lock = 1'b1;
    step(15);
    chk("t4_req_early",  ready, 32'd0);
    step(1);
    chk("t4_req_ready",  ready, 32'd1);
    chk("t4_lost_end",   lost_cnt, 32'd1);

    // 5: force_relock in the cycle the synchronised lock drops
    lock = 1'b0;
    step(2);
    chk("t5_still_run",  state_o, 32'd4);
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    chk("t5_state_rst",  state_o, 32'd0);
    chk("t5_lost2",      lost_cnt, 32'd2);
    chk("t5_pll_rst",    pll_rst, 32'd1);
    chk("t5_rst_out",    rst_out, 32'd1);
    step(3);
    chk("t5_pll_rst_hi", pll_rst, 32'd1);
    step(1);
    chk("t5_pll_rst_lo", pll_rst, 32'd0);
    chk("t5_wait",       state_o, 32'd1);

    // force_relock outside RUN, and counter restart inside PLL_RST
    step(5);
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    chk("tf_wait_force", state_o, 32'd0);
    chk("tf_retry_same", retry_cnt, 32'd1);
    step(2);
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    step(3);
    chk("tf_restart_st", state_o, 32'd0);
    step(1);
    chk("tf_restart_dn", state_o, 32'd1);

    // 6: asynchronous reset during HOLD, then retry saturation
    lock = 1'b1;
    step(12);
    chk("t6_in_hold",    state_o, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_st",   state_o,   32'd0);
    chk("t6_async_pll",  pll_rst,   32'd1);
    chk("t6_async_rout", rst_out,   32'd1);
    chk("t6_async_rdy",  ready,     32'd0);
    chk("t6_async_lost", lost_cnt,  32'd0);
    chk("t6_async_rtry", retry_cnt, 32'd0);
    lock = 1'b0;
    @(negedge clkin);
    reset = 1'b0;
    step(108);
    chk("t6_retry2",     retry_cnt, 32'd2);
    step(300 * 54 - 108 + 5);
    chk("t6_retry_sat",  retry_cnt, 32'd255);
    chk("t6_lost_zero",  lost_cnt,  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
